// File: rtl/branch_resolve.sv
// branch_resolve: resolves RISC-V style conditional branches (condition,
// target, illegal-encoding and misalignment flags) into a one-entry output
// register with a valid/ready handshake on both sides.
// Optional feature macro: BRANCH_RESOLVE_STATS_EN adds handshake counters
// branch_cnt_o and taken_cnt_o.

// 32-bit unsigned magnitude comparator
module cmp_32u (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        equal,
  output logic        alarger,
  output logic        blarger
);

  assign equal   = (a == b);
  assign alarger = (a > b);
  assign blarger = (a < b);

endmodule

module branch_resolve (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] imm_i,
  input  logic        flush_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic        taken_o,
  output logic [31:0] target_o,
  output logic        illegal_o,
  output logic        misalign_o
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  output logic [31:0] branch_cnt_o,
  output logic [31:0] taken_cnt_o
`endif
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t      state_r;
  logic        valid_r;
  logic        taken_r;
  logic        illegal_r;
  logic        misalign_r;
  logic [31:0] target_r;

  logic        u_eq_s, u_agt_s, u_bgt_s;
  logic        s_eq_s, s_agt_s, s_bgt_s;
  logic        taken_s;
  logic        illegal_s;
  logic        misalign_s;
  logic [31:0] target_s;
  logic [31:0] sum_taken_s;
  logic [31:0] sum_seq_s;
  logic        accept_s;

  // Unsigned compare of the raw operands
  cmp_32u u_cmp_unsigned (
    .a       (rs1_i),
    .b       (rs2_i),
    .equal   (u_eq_s),
    .alarger (u_agt_s),
    .blarger (u_bgt_s)
  );

  // Flipping the sign bits maps two's-complement order onto unsigned order
  cmp_32u u_cmp_signed (
    .a       ({~rs1_i[31], rs1_i[30:0]}),
    .b       ({~rs2_i[31], rs2_i[30:0]}),
    .equal   (s_eq_s),
    .alarger (s_agt_s),
    .blarger (s_bgt_s)
  );

  // Both sums wrap modulo 2^32; the carry out is dropped on purpose
  assign sum_taken_s = pc_i + imm_i;
  assign sum_seq_s   = pc_i + 32'd4;

  assign ready_o  = ~valid_r | ready_i;
  assign accept_s = valid_i & ready_o;

  // Branch condition, target and exception flags for the presented operands
  always_comb begin
    taken_s   = 1'b0;
    illegal_s = 1'b0;
    case (funct3_i)
      3'b000:  taken_s = u_eq_s;
      3'b001:  taken_s = ~u_eq_s;
      3'b100:  taken_s = s_bgt_s;
      3'b101:  taken_s = s_eq_s | s_agt_s;
      3'b110:  taken_s = u_bgt_s;
      3'b111:  taken_s = u_eq_s | u_agt_s;
      3'b010,
      3'b011:  illegal_s = 1'b1;
      default: taken_s = 1'b0;
    endcase
    target_s   = taken_s ? sum_taken_s : sum_seq_s;
    misalign_s = taken_s & (target_s[1:0] != 2'b00);
  end

  // Output register state machine; flush beats accept and drain
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r    <= EMPTY;
      valid_r    <= 1'b0;
      taken_r    <= 1'b0;
      illegal_r  <= 1'b0;
      misalign_r <= 1'b0;
      target_r   <= 32'h0000_0000;
    end else if (flush_i) begin
      state_r    <= EMPTY;
      valid_r    <= 1'b0;
      taken_r    <= 1'b0;
      illegal_r  <= 1'b0;
      misalign_r <= 1'b0;
      target_r   <= 32'h0000_0000;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_r    <= FULL;
            valid_r    <= 1'b1;
            taken_r    <= taken_s;
            illegal_r  <= illegal_s;
            misalign_r <= misalign_s;
            target_r   <= target_s;
          end else begin
            state_r    <= EMPTY;
            valid_r    <= 1'b0;
          end
        end
        FULL: begin
          if (accept_s) begin
            state_r    <= FULL;
            valid_r    <= 1'b1;
            taken_r    <= taken_s;
            illegal_r  <= illegal_s;
            misalign_r <= misalign_s;
            target_r   <= target_s;
          end else if (ready_i) begin
            state_r    <= EMPTY;
            valid_r    <= 1'b0;
            taken_r    <= 1'b0;
            illegal_r  <= 1'b0;
            misalign_r <= 1'b0;
            target_r   <= 32'h0000_0000;
          end else begin
            state_r    <= FULL;
            valid_r    <= 1'b1;
          end
        end
        default: begin
          state_r    <= EMPTY;
          valid_r    <= 1'b0;
          taken_r    <= 1'b0;
          illegal_r  <= 1'b0;
          misalign_r <= 1'b0;
          target_r   <= 32'h0000_0000;
        end
      endcase
    end
  end

  assign valid_o    = valid_r;
  assign taken_o    = taken_r;
  assign illegal_o  = illegal_r;
  assign misalign_o = misalign_r;
  assign target_o   = target_r;

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] branch_cnt_r;
  logic [31:0] taken_cnt_r;

  // Count output handshakes and taken handshakes; both wrap, flush leaves them alone
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      branch_cnt_r <= 32'h0000_0000;
      taken_cnt_r  <= 32'h0000_0000;
    end else if (valid_r & ready_i) begin
      branch_cnt_r <= branch_cnt_r + 32'd1;
      taken_cnt_r  <= taken_r ? (taken_cnt_r + 32'd1) : taken_cnt_r;
    end else begin
      branch_cnt_r <= branch_cnt_r;
      taken_cnt_r  <= taken_cnt_r;
    end
  end

  assign branch_cnt_o = branch_cnt_r;
  assign taken_cnt_o  = taken_cnt_r;
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Directed self-checking bench for branch_resolve. Result outputs are
// compared as one packed word {valid, taken, illegal, misalign, target}.
module tb_branch_resolve;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] rs1_i;
  logic [31:0] rs2_i;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i;
  logic [31:0] imm_i;
  logic        flush_i;
  logic        valid_o;
  logic        ready_i;
  logic        taken_o;
  logic [31:0] target_o;
  logic        illegal_o;
  logic        misalign_o;
`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] branch_cnt_o;
  logic [31:0] taken_cnt_o;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;

  branch_resolve dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .funct3_i   (funct3_i),
    .pc_i       (pc_i),
    .imm_i      (imm_i),
    .flush_i    (flush_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .taken_o    (taken_o),
    .target_o   (target_o),
    .illegal_o  (illegal_o),
    .misalign_o (misalign_o)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .branch_cnt_o (branch_cnt_o),
    .taken_cnt_o  (taken_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [35:0] outs();
    return {valid_o, taken_o, illegal_o, misalign_o, target_o};
  endfunction

  // Present one operand set with ready_i high, clock once, then drop valid_i
  task automatic apply(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic [31:0] imm);
    funct3_i = f3; rs1_i = a; rs2_i = b; pc_i = pc; imm_i = imm;
    valid_i = 1'b1; ready_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
  endtask

  task automatic drain();
    valid_i = 1'b0; ready_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; flush_i = 1'b0;
    rs1_i = 32'h0; rs2_i = 32'h0; funct3_i = 3'b000; pc_i = 32'h0; imm_i = 32'h0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    vec_cnt++;
    if (outs() !== 36'h0_0000_0000) begin
      $display("FAIL reset_outs: got %h expected %h", outs(), 36'h0_0000_0000); err_cnt++;
    end
    vec_cnt++;
    if (ready_o !== 1'b1) begin
      $display("FAIL reset_ready: got %b expected 1", ready_o); err_cnt++;
    end
    // Reset while a result is held and the consumer stalls
    funct3_i = BEQ; rs1_i = 32'h7; rs2_i = 32'h7; pc_i = 32'h40; imm_i = 32'h8;
    valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    vec_cnt++;
    if (outs() !== {4'b1100, 32'h48}) begin
      $display("FAIL reset_preload: got %h expected %h", outs(), {4'b1100, 32'h48}); err_cnt++;
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    vec_cnt++;
    if ({ready_o, outs()} !== {1'b1, 36'h0_0000_0000}) begin
      $display("FAIL reset_midxfer: got %h expected %h", {ready_o, outs()}, {1'b1, 36'h0}); err_cnt++;
    end
  endtask

  task automatic test_conditions();
    logic [2:0]  f3  [8]  = '{BLT, BLTU, BGE, BGEU, BEQ, BNE, BEQ, BNE};
    logic [31:0] a   [8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                              32'h1234_5678, 32'h1234_5678, 32'hA, 32'h5};
    logic [31:0] b   [8]  = '{32'h1, 32'h1, 32'h1, 32'h1,
                              32'h1234_5678, 32'h1234_5678, 32'hA, 32'h5};
    logic [31:0] pc  [8]  = '{32'h100, 32'h100, 32'h200, 32'h200,
                              32'h300, 32'h300, 32'hFFFF_FFF0, 32'hFFFF_FFFC};
    logic [31:0] imm [8]  = '{32'h20, 32'h20, 32'h10, 32'hFFFF_FFF0,
                              32'h40, 32'h40, 32'h10, 32'h40};
    logic [35:0] exp [8]  = '{{4'b1100, 32'h120}, {4'b1000, 32'h104},
                              {4'b1000, 32'h204}, {4'b1100, 32'h1F0},
                              {4'b1100, 32'h340}, {4'b1000, 32'h304},
                              {4'b1100, 32'h0},   {4'b1000, 32'h0}};
    for (int i = 0; i < 8; i++) begin
      apply(f3[i], a[i], b[i], pc[i], imm[i]);
      vec_cnt++;
      if (outs() !== exp[i]) begin
        $display("FAIL cond_%0d: got %h expected %h", i, outs(), exp[i]); err_cnt++;
      end
    end
    drain();
    vec_cnt++;
    if (outs() !== 36'h0) begin
      $display("FAIL cond_drain: got %h expected %h", outs(), 36'h0); err_cnt++;
    end
  endtask

  task automatic test_backpressure();
    funct3_i = BEQ; rs1_i = 32'h5; rs2_i = 32'h5; pc_i = 32'h200; imm_i = 32'h40;
    valid_i = 1'b1; ready_i = 1'b0;
    @(posedge clk_i); #1;
    // A different branch sits on the inputs while stalled; it must be ignored
    funct3_i = BNE; rs1_i = 32'h1; rs2_i = 32'h2; pc_i = 32'h300; imm_i = 32'h8;
    for (int i = 0; i < 3; i++) begin
      vec_cnt++;
      if ({ready_o, outs()} !== {1'b0, 4'b1100, 32'h240}) begin
        $display("FAIL stall_%0d: got %h expected %h", i, {ready_o, outs()}, {1'b0, 4'b1100, 32'h240});
        err_cnt++;
      end
      @(posedge clk_i); #1;
    end
    vec_cnt++;
    if (outs() !== {4'b1100, 32'h240}) begin
      $display("FAIL stall_end: got %h expected %h", outs(), {4'b1100, 32'h240}); err_cnt++;
    end
    ready_i = 1'b1;
    #1;
    vec_cnt++;
    if (ready_o !== 1'b1) begin
      $display("FAIL bp_ready: got %b expected 1", ready_o); err_cnt++;
    end
    @(posedge clk_i); #1;
    vec_cnt++;
    if (outs() !== {4'b1100, 32'h308}) begin
      $display("FAIL back_to_back_1: got %h expected %h", outs(), {4'b1100, 32'h308}); err_cnt++;
    end
    funct3_i = BEQ; rs1_i = 32'h1; rs2_i = 32'h2; pc_i = 32'h400; imm_i = 32'h8;
    @(posedge clk_i); #1;
    vec_cnt++;
    if (outs() !== {4'b1000, 32'h404}) begin
      $display("FAIL back_to_back_2: got %h expected %h", outs(), {4'b1000, 32'h404}); err_cnt++;
    end
    drain();
  endtask

  task automatic test_flush();
    funct3_i = BEQ; rs1_i = 32'h3; rs2_i = 32'h3; pc_i = 32'h500; imm_i = 32'h10;
    valid_i = 1'b1; ready_i = 1'b0; flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    vec_cnt++;
    if (outs() !== 36'h0) begin
      $display("FAIL flush_accept: got %h expected %h", outs(), 36'h0); err_cnt++;
    end
    valid_i = 1'b1;
    @(posedge clk_i); #1;
    vec_cnt++;
    if (outs() !== {4'b1100, 32'h510}) begin
      $display("FAIL flush_load: got %h expected %h", outs(), {4'b1100, 32'h510}); err_cnt++;
    end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0; valid_i = 1'b0;
    vec_cnt++;
    if ({ready_o, outs()} !== {1'b1, 36'h0}) begin
      $display("FAIL flush_held: got %h expected %h", {ready_o, outs()}, {1'b1, 36'h0}); err_cnt++;
    end
  endtask

  task automatic test_illegal_misalign();
    apply(3'b010, 32'h9, 32'h9, 32'h600, 32'h20);
    vec_cnt++;
    if (outs() !== {4'b1010, 32'h604}) begin
      $display("FAIL illegal_010: got %h expected %h", outs(), {4'b1010, 32'h604}); err_cnt++;
    end
    apply(3'b011, 32'h1, 32'h9, 32'h700, 32'h20);
    vec_cnt++;
    if (outs() !== {4'b1010, 32'h704}) begin
      $display("FAIL illegal_011: got %h expected %h", outs(), {4'b1010, 32'h704}); err_cnt++;
    end
    apply(BEQ, 32'h4, 32'h4, 32'h100, 32'h2);
    vec_cnt++;
    if (outs() !== {4'b1101, 32'h102}) begin
      $display("FAIL misalign_taken: got %h expected %h", outs(), {4'b1101, 32'h102}); err_cnt++;
    end
    apply(BNE, 32'h4, 32'h4, 32'h100, 32'h2);
    vec_cnt++;
    if (outs() !== {4'b1000, 32'h104}) begin
      $display("FAIL misalign_nottaken: got %h expected %h", outs(), {4'b1000, 32'h104}); err_cnt++;
    end
    drain();
  endtask

`ifdef BRANCH_RESOLVE_STATS_EN
  task automatic test_stats();
    rst_i = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    apply(BEQ, 32'h1, 32'h1, 32'h0, 32'h8);
    apply(BNE, 32'h1, 32'h1, 32'h0, 32'h8);
    apply(BLT, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h8);
    apply(BLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h8);
    apply(BGEU, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h8);
    drain();
    vec_cnt++;
    if ({branch_cnt_o, taken_cnt_o} !== {32'd5, 32'd3}) begin
      $display("FAIL stats_count: got %0d/%0d expected 5/3", branch_cnt_o, taken_cnt_o); err_cnt++;
    end
    flush_i = 1'b1;
    @(posedge clk_i); #1;
    flush_i = 1'b0;
    vec_cnt++;
    if ({branch_cnt_o, taken_cnt_o} !== {32'd5, 32'd3}) begin
      $display("FAIL stats_flush: got %0d/%0d expected 5/3", branch_cnt_o, taken_cnt_o); err_cnt++;
    end
    dut.branch_cnt_r = 32'hFFFF_FFFF;
    apply(BNE, 32'h1, 32'h1, 32'h0, 32'h8);
    drain();
    vec_cnt++;
    if ({branch_cnt_o, taken_cnt_o} !== {32'd0, 32'd3}) begin
      $display("FAIL stats_wrap: got %h/%0d expected 0/3", branch_cnt_o, taken_cnt_o); err_cnt++;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_conditions();
    test_backpressure();
    test_flush();
    test_illegal_misalign();
`ifdef BRANCH_RESOLVE_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
